// File: rtl/ode_pkg.sv
//============================================================================
// ode_pkg - shared types and constants for the ODE accelerator (rev 1.0)
//============================================================================
`default_nettype none

package ode_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_priority_picker.sv
//============================================================================
// rr_priority_picker - rotating-priority winner select, search from last+1 (rev 1.0)
//============================================================================
`default_nettype none

module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDXW-1:0]    last_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic [IDXW-1:0]    idx_o
);

  logic            w_found;
  logic [IDXW-1:0] w_pos;

  always_comb begin
    winner_o = '0;
    idx_o    = '0;
    w_found  = 1'b0;
    w_pos    = '0;
    // Offset 1 first, so the previous owner is examined last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_pos = IDXW'((int'(last_i) + k) % NUM_REQ);
      if (!w_found && req_i[w_pos]) begin
        w_found         = 1'b1;
        winner_o[w_pos] = 1'b1;
        idx_o           = w_pos;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/multiplier_arbiter.sv
//============================================================================
// multiplier_arbiter - round-robin sharing of one multiplier with watchdog (rev 1.0)
//============================================================================
`default_nettype none

module multiplier_arbiter
  import ode_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DATA_WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] operand_a,
  input  logic [NUM_REQ*WIDTH-1:0] operand_b,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         result,
  output logic                     overflow,
  output logic                     timeout,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic                     mul_done,
  input  logic [WIDTH-1:0]         mul_result,
  input  logic                     mul_overflow
);

  localparam int              IDXW     = $clog2(NUM_REQ);
  localparam int              CNTW     = $clog2(TIMEOUT);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_REQ - 1);

  arb_state_t           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 mul_start_q, mul_start_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 overflow_q, overflow_d;
  logic                 timeout_q, timeout_d;
  logic [IDXW-1:0]      last_q, last_d;
  logic [IDXW-1:0]      owner_q, owner_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   w_pick_onehot;
  logic [IDXW-1:0]      w_pick_idx;
  logic                 w_any_req;
  logic                 w_wd_expired;
  logic [WIDTH-1:0]     w_opa [NUM_REQ];
  logic [WIDTH-1:0]     w_opb [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_opa[gi] = operand_a[gi*WIDTH +: WIDTH];
    assign w_opb[gi] = operand_b[gi*WIDTH +: WIDTH];
  end

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_picker (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (w_pick_onehot),
    .idx_o    (w_pick_idx)
  );

  assign w_any_req    = |req;
  assign w_wd_expired = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_any_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mul_done || w_wd_expired) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d     = grant_q;
    done_d      = '0;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    timeout_d   = timeout_q;
    last_d      = last_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (w_any_req) begin
          grant_d     = w_pick_onehot;
          owner_d     = w_pick_idx;
          mul_a_d     = w_opa[w_pick_idx];
          mul_b_d     = w_opb[w_pick_idx];
          mul_start_d = 1'b1;
        end
      end
      ISSUE: cnt_d = '0;
      WAIT: begin
        // A real completion wins over an expiry in the same cycle.
        if (mul_done) begin
          result_d   = mul_result;
          overflow_d = mul_overflow;
          timeout_d  = 1'b0;
          done_d     = grant_q;
        end else if (w_wd_expired) begin
          result_d   = '0;
          overflow_d = 1'b0;
          timeout_d  = 1'b1;
          done_d     = grant_q;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      RESPOND: begin
        last_d  = owner_q;
        grant_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_q     <= '0;
      done_q      <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      last_q      <= IDX_LAST;
      owner_q     <= '0;
      cnt_q       <= '0;
    end else begin
      grant_q     <= grant_d;
      done_q      <= done_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign timeout   = timeout_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

`default_nettype wire

// File: doc/multiplier_arbiter.md
# multiplier_arbiter

Round-robin arbiter that shares the single fixed-point multiplier of the ODE accelerator between several requesters: the step-control FSM, the integrator stage and the error accumulator. It serialises their start/done transactions onto one multiplier, routes operands in and the result, overflow and timeout flags back, and guards against a hung multiplier with a watchdog. It sits between the requester FSMs and the multiplier instance in the accelerator top level.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- WIDTH, 32: fixed-point operand/result width.
- TIMEOUT, 64: maximum WAIT cycles before abort (≥ 2).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level. Held high with operands stable until that requester's done pulse.
- operand_a  in  NUM_REQ*WIDTH  packed operand A. Requester i occupies bits [i*WIDTH +: WIDTH].
- operand_b  in  NUM_REQ*WIDTH  packed operand B, same packing as operand_a.
- grant  out  NUM_REQ  one-hot owner of the current transaction. All zero when idle.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- result  out  WIDTH  multiplier result, valid while any done bit is high.
- overflow  out  1  multiplier overflow, valid with done.
- timeout  out  1  watchdog abort, valid with done.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a, mul_b  out  WIDTH  registered operands to the multiplier.
- mul_done  in  1  multiplier completion.
- mul_result  in  WIDTH  multiplier result.
- mul_overflow  in  1  multiplier overflow flag.

## Operation
- States: IDLE, ISSUE, WAIT, RESPOND.
- **IDLE**
  - If req is nonzero, pick a winner by rotating priority starting at last+1 (mod NUM_REQ).
  - Register grant one-hot, latch the winner's operands into mul_a/mul_b, go to ISSUE.
- **ISSUE**
  - mul_start=1 for exactly one cycle.
  - Clear the watchdog counter, go to WAIT.
- **WAIT**
  - On mul_done: latch mul_result and mul_overflow, timeout=0, go to RESPOND.
  - Otherwise increment the counter. When it reaches TIMEOUT-1 without mul_done: result=0, overflow=0, timeout=1, go to RESPOND.
- **RESPOND**
  - done[owner]=1 for one cycle; result, overflow and timeout are held.
  - Set last=owner, clear grant, go to IDLE.
- Fairness: a requester that has just been served has lowest priority in the next arbitration.
- Operands are sampled only in the IDLE→ISSUE transition. Later operand changes do not affect the transaction.
- A requester dropping req mid-transaction does not abort it. The done pulse still issues and the result is discarded by the requester.
- A requester that keeps req high after done is re-arbitrated normally. It wins again only if no other req is set.
- mul_done while in IDLE, ISSUE or RESPOND is ignored.
- result, overflow and timeout hold their last values outside RESPOND. Only the done pulse qualifies them.

## Timing
- Reset (rst=0 at an edge):
  - State IDLE; grant, done, mul_start, mul_a, mul_b, result, overflow, timeout all 0.
  - last=NUM_REQ-1, so requester 0 has first priority.
  - Takes precedence over every event, including mid-WAIT. The multiplier is not signalled; its later mul_done is ignored.
- Latency:
  - req seen at edge E gives grant and ISSUE from E+1, mul_start high during cycle E+1.
  - mul_done high during cycle k of WAIT gives RESPOND during the next cycle.
  - Earliest next grant is two cycles after the done pulse begins.
- Minimum transaction, with mul_done in the first WAIT cycle: req→done = 4 cycles.
- Simultaneous requests: exactly one grant per arbitration. The others wait and are served in rotation order.
- Watchdog: RESPOND with timeout=1 occurs TIMEOUT cycles after entering WAIT.
- No combinational path from req, operand_* or mul_* to any output. All outputs are registered.

## Structure
- Shared package ode_pkg:
  - arb_state_t enum (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESPOND=2'd3).
  - DATA_WIDTH constant, reused as the WIDTH default.
- Sub-module rr_priority_picker: combinational. Takes req and last, returns one-hot winner and its index.
- The arbiter holds the FSM, the watchdog counter and the registers.

## Test plan
- **Reset mid-WAIT:** rst=0 → all outputs 0 next edge. A subsequent req=4'b0100 is granted requester 2 with no stale done.
- **Single request:** req=4'b0001, a=0x0002_0000, b=0x0003_0000, mul_done 3 cycles after mul_start with mul_result=0x0006_0000 → done=4'b0001, result=0x0006_0000, overflow=0, timeout=0.
- **Contention:** req=4'b1011 held continuously → grant order 0,1,3,0,1,3; each done pulse is one cycle wide.
- **Overflow passthrough:** mul_overflow=1 with mul_done → done[owner]=1, overflow=1; next transaction shows overflow=0.
- **Watchdog:** mul_done never asserted, TIMEOUT=64 → done 64 cycles after entering WAIT with timeout=1, result=0. A late mul_done is then ignored.
- **Operand stability:** operand_a of the owner changed during WAIT → mul_a unchanged and result reflects the originally latched operands.
